alu_interface: RTL and testbench
================================

ALU_INTERFACE -- requirements
Module: alu_interface

Interface
REQ-001 SHALL have parameter NB_OPERANDO, default 8, operand width.
REQ-002 SHALL have parameter NB_OPCODE, default 6, opcode width.
REQ-003 SHALL have parameter NB_OUT, default 8, ALU result width.
REQ-004 SHALL have parameter NB_DATA, default 8, serial byte width.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rx_data  input  NB_DATA  byte from UART receiver.
REQ-008 rx_done  input  1  one-cycle strobe: rx_data valid.
REQ-009 tx_done  input  1  one-cycle strobe: UART transmitter finished the byte.
REQ-010 alu_out  input  NB_OUT  combinational result from the ALU.
REQ-011 dato_a  output  NB_OPERANDO  latched operand A to the ALU.
REQ-012 dato_b  output  NB_OPERANDO  latched operand B to the ALU.
REQ-013 opcode  output  NB_OPCODE  latched opcode to the ALU.
REQ-014 tx_data  output  NB_DATA  result byte to the UART transmitter.
REQ-015 tx_start  output  1  one-cycle request to send tx_data.
REQ-016 op_error  output  1  one-cycle pulse: illegal opcode rejected.

Function
REQ-017 SHALL implement FSM states WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX.
REQ-018 WAIT_A + rx_done: dato_a <= rx_data[NB_OPERANDO-1:0], go WAIT_B; otherwise hold.
REQ-019 WAIT_B + rx_done: dato_b <= rx_data[NB_OPERANDO-1:0], go WAIT_OP; otherwise hold.
REQ-020 WAIT_OP + rx_done: opcode <= rx_data[NB_OPCODE-1:0], go SEND (subject to REQ-031).
REQ-021 SEND (exactly one cycle): tx_data <= alu_out, tx_start <= 1, go WAIT_TX.
REQ-022 tx_start SHALL be high exactly one cycle: the cycle after SEND; two edges after the edge sampling the opcode rx_done.
REQ-023 WAIT_TX + tx_done: go WAIT_A; tx_done in the same cycle tx_start is high SHALL be honored.
REQ-024 rx_done in SEND or WAIT_TX SHALL be ignored; no register changes.
REQ-025 tx_done outside WAIT_TX SHALL be ignored.
REQ-026 dato_a, dato_b, opcode SHALL hold their values until overwritten by a new received byte; tx_data SHALL hold until the next SEND.
REQ-027 Width rule: NB_OUT > NB_DATA truncates to LSBs; NB_OUT < NB_DATA zero-extends.
REQ-028 Back-to-back rx_done in consecutive cycles SHALL each be accepted in sequence.

Reset
REQ-029 reset high at a rising edge SHALL force state WAIT_A and dato_a, dato_b, opcode, tx_data, tx_start, op_error to 0, from any state, overriding simultaneous rx_done/tx_done.
REQ-030 Reset mid-sequence (after A or B received) SHALL discard partial data; the next rx_done is treated as operand A.

Configuration
REQ-031 Macro OPCODE_CHECK_EN defined: in WAIT_OP, rx_done with rx_data[NB_OPCODE-1:0] not in {100000,100010,100100,100101,100110,100111,000011,000010} SHALL leave opcode unchanged, pulse op_error one cycle, return to WAIT_A, no tx_start.
REQ-032 Macro OPCODE_CHECK_EN undefined: every opcode accepted per REQ-020; op_error tied to 0.

Verification (bench instantiates ALU on dato_a/dato_b/opcode/alu_out, default parameters)
REQ-033 rx bytes 0x05, 0x03, 0x20 -> tx_start one pulse two edges after third rx_done, tx_data 0x08; tx_done -> WAIT_A.
REQ-034 rx 0x03, 0x05, 0x22 -> tx_data 0xFE; rx 0x80, 0x02, 0x03 -> tx_data 0xE0.
REQ-035 rx 0x11, then reset one cycle, then 0x0F, 0xF0, 0x25 -> dato_a 0x0F, tx_data 0xFF; all outputs 0 right after reset.
REQ-036 after 0x01,0x01,0x20, rx_done with 0x55 while in WAIT_TX -> dato_a unchanged (0x01); tx_done then rx 0x02,0x02,0x24 -> tx_data 0x02.
REQ-037 rx 0x07, 0x01, 0x3F: with OPCODE_CHECK_EN -> op_error one pulse, no tx_start, opcode unchanged; without -> tx_start, tx_data 0x00.

Source files
------------

// File: rtl/alu_interface.sv
// alu_interface: sequences bytes from a UART receiver into ALU operands
// (A, then B, then opcode), captures the ALU result and hands it to the
// UART transmitter, then waits for the transmitter to finish.
//
// Optional feature: define OPCODE_CHECK_EN to reject opcodes outside the
// supported ALU set. A rejected opcode leaves the opcode register alone,
// pulses op_error for one cycle and restarts the sequence at operand A.
// Without the macro every opcode is accepted and op_error stays 0.
//
// Handshake: rx_done and tx_done are single-cycle strobes with no
// back-pressure; a strobe is consumed only in the state that expects it
// and is silently dropped elsewhere. tx_start is a single-cycle request
// and tx_data stays stable until the next result is captured.
//
// state_dbg mirrors the FSM state for observation only.
module alu_interface #(
  parameter int NB_OPERANDO = 8,
  parameter int NB_OPCODE   = 6,
  parameter int NB_OUT      = 8,
  parameter int NB_DATA     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NB_DATA-1:0]     rx_data,
  input  logic                   rx_done,
  input  logic                   tx_done,
  input  logic [NB_OUT-1:0]      alu_out,
  output logic [NB_OPERANDO-1:0] dato_a,
  output logic [NB_OPERANDO-1:0] dato_b,
  output logic [NB_OPCODE-1:0]   opcode,
  output logic [NB_DATA-1:0]     tx_data,
  output logic                   tx_start,
  output logic                   op_error,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t state;

  logic [NB_DATA-1:0] alu_byte;
  logic               op_ok;

  assign state_dbg = state;

  // Fit the ALU result into one serial byte: keep LSBs or zero-extend.
  generate
    if (NB_OUT >= NB_DATA) begin : g_trunc
      assign alu_byte = alu_out[NB_DATA-1:0];
    end else begin : g_zext
      assign alu_byte = {{(NB_DATA-NB_OUT){1'b0}}, alu_out};
    end
  endgenerate

`ifdef OPCODE_CHECK_EN
  // Opcode is legal when it names one of the ALU's eight operations.
  always_comb begin
    op_ok = 1'b0;
    case (rx_data[NB_OPCODE-1:0])
      NB_OPCODE'(6'b100000),
      NB_OPCODE'(6'b100010),
      NB_OPCODE'(6'b100100),
      NB_OPCODE'(6'b100101),
      NB_OPCODE'(6'b100110),
      NB_OPCODE'(6'b100111),
      NB_OPCODE'(6'b000011),
      NB_OPCODE'(6'b000010): op_ok = 1'b1;
      default:               op_ok = 1'b0;
    endcase
  end
`else
  assign op_ok = 1'b1;
`endif

  // Byte sequencer FSM with registered operand/result/strobe outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= WAIT_A;
      dato_a   <= '0;
      dato_b   <= '0;
      opcode   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      op_error <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      op_error <= 1'b0;
      case (state)
        WAIT_A: begin
          if (rx_done) begin
            dato_a <= rx_data[NB_OPERANDO-1:0];
            state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done) begin
            dato_b <= rx_data[NB_OPERANDO-1:0];
            state  <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (rx_done) begin
            if (op_ok) begin
              opcode <= rx_data[NB_OPCODE-1:0];
              state  <= SEND;
            end else begin
              op_error <= 1'b1;
              state    <= WAIT_A;
            end
          end
        end
        // One cycle so the ALU sees the freshly latched opcode.
        SEND: begin
          tx_data  <= alu_byte;
          tx_start <= 1'b1;
          state    <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            state <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_interface.sv
// tb_alu_interface: directed and randomized transactions through
// alu_interface with a simple ALU attached, checked against an arithmetic
// reference model and an expected-result queue.
module tb_alu_interface;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_out;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [5:0] opcode;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       op_error;
  logic [2:0] state_dbg;

`ifdef OPCODE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [5:0] legal_ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  logic [5:0] m_op;
  logic [7:0] m_tx;

  alu_interface dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_done   (tx_done),
    .alu_out   (alu_out),
    .dato_a    (dato_a),
    .dato_b    (dato_b),
    .opcode    (opcode),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .op_error  (op_error),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU attached to the interface outputs
  always_comb begin
    case (opcode)
      6'h20:   alu_out = dato_a + dato_b;
      6'h22:   alu_out = dato_a - dato_b;
      6'h24:   alu_out = dato_a & dato_b;
      6'h25:   alu_out = dato_a | dato_b;
      6'h26:   alu_out = dato_a ^ dato_b;
      6'h27:   alu_out = ~(dato_a | dato_b);
      6'h03:   alu_out = $signed(dato_a) >>> dato_b;
      6'h02:   alu_out = dato_a >> dato_b;
      default: alu_out = 8'h00;
    endcase
  end

  // reference model: integer arithmetic on the operand values
  function automatic logic [7:0] model_result(input int a, input int b, input int op);
    int r;
    int sa;
    sa = (a >= 128) ? a - 256 : a;
    case (op)
      32:      r = a + b;
      34:      r = a - b;
      36:      r = a & b;
      37:      r = a | b;
      38:      r = a ^ b;
      39:      r = ~(a | b);
      3:       r = (b >= 8) ? ((sa < 0) ? -1 : 0) : (sa / (1 << b)) - (((sa < 0) && (sa % (1 << b) != 0)) ? 1 : 0);
      2:       r = (b >= 8) ? 0 : a / (1 << b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] v);
    @(negedge clock);
    rx_data = v;
    rx_done = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_done = 1'b0;
      tx_done = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input int gap, input int tx_wait, input bit junk);
    bit accept;
    accept = !CHECK_EN || is_legal(op);
    send_byte(a);
    idle(gap);
    send_byte(b);
    check("dato_a", dato_a, a);
    idle(gap);
    send_byte(op);
    check("dato_b", dato_b, b);
    @(negedge clock);
    rx_done = 1'b0;
    if (accept) begin
      m_op = op;
      exp_q.push_back(model_result(a, b, op));
      check("opcode", opcode, op);
      check("tx_start_early", tx_start, 1'b0);
      check("op_error_clr", op_error, 1'b0);
      @(negedge clock);
      m_tx = exp_q.pop_front();
      check("tx_start_pulse", tx_start, 1'b1);
      check("tx_data", tx_data, m_tx);
      if (junk) begin
        rx_data = 8'h55;
        rx_done = 1'b1;
      end
      repeat (tx_wait) begin
        @(negedge clock);
        rx_done = 1'b0;
        check("tx_start_hold_low", tx_start, 1'b0);
      end
      tx_done = 1'b1;
      @(negedge clock);
      tx_done = 1'b0;
      rx_done = 1'b0;
      check("tx_start_end", tx_start, 1'b0);
      check("dato_a_kept", dato_a, a);
      check("tx_data_kept", tx_data, m_tx);
    end else begin
      check("op_error_pulse", op_error, 1'b1);
      check("tx_start_none", tx_start, 1'b0);
      check("opcode_kept", opcode, m_op);
      @(negedge clock);
      check("op_error_end", op_error, 1'b0);
      check("tx_start_none2", tx_start, 1'b0);
    end
  endtask

  task automatic check_all_zero();
    check("rst_dato_a", dato_a, 8'h00);
    check("rst_dato_b", dato_b, 8'h00);
    check("rst_opcode", opcode, 6'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_op_error", op_error, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    m_op    = 6'h00;
    m_tx    = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_all_zero();

    // directed: add, sub, arithmetic shift
    run_txn(8'h05, 8'h03, 6'h20, 0, 0, 1'b0);
    check("add_result", tx_data, 8'h08);
    run_txn(8'h03, 8'h05, 6'h22, 0, 2, 1'b0);
    check("sub_result", tx_data, 8'hFE);
    run_txn(8'h80, 8'h02, 6'h03, 1, 1, 1'b0);
    check("sra_result", tx_data, 8'hE0);

    // reset mid-sequence, overriding a simultaneous rx_done
    send_byte(8'h11);
    @(negedge clock);
    reset   = 1'b1;
    rx_data = 8'h33;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    m_op    = 6'h00;
    check_all_zero();
    run_txn(8'h0F, 8'hF0, 6'h25, 0, 0, 1'b0);
    check("or_after_reset", tx_data, 8'hFF);

    // rx_done while waiting for the transmitter is ignored
    run_txn(8'h01, 8'h01, 6'h20, 0, 1, 1'b1);
    run_txn(8'h02, 8'h02, 6'h24, 0, 0, 1'b0);
    check("and_result", tx_data, 8'h02);

    // stray tx_done in WAIT_A is ignored
    @(negedge clock);
    tx_done = 1'b1;
    idle(1);

    // unsupported opcode
    run_txn(8'h07, 8'h01, 6'h3F, 0, 0, 1'b0);
    if (!CHECK_EN) check("illegal_passthru", tx_data, 8'h00);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else                           op = legal_ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clock);
        tx_done = 1'b1;
        idle(1);
      end
      run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), op,
              $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    idle(2);
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
